// File: rtl/core_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access
// encodings, the access FSM state type and the access legality check.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    // Returns 1 when the access must not be issued: a funct3 that is not
    // legal for this direction, or an address not aligned to the width.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic bad_f3;
        logic misaligned;
        if (is_store) begin
            bad_f3 = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end else begin
            bad_f3 = !((funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU));
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return bad_f3 | misaligned;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data extraction: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the lane named by the low address bits and extend it.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_HU:   data = {16'h0000, half_s};
            F3_W:    data = rdata;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one handshaked data-memory access per
// load/store in EX/MEM, stalls the pipeline while it is outstanding, and
// returns extended load data (or a bus error after MAX_WAIT busy cycles).
module mem_stage_lsu
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_alu_result_in,
    input  logic [31:0] mem_store_data_in,
    input  logic [2:0]  mem_funct3_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        stall_out,
    output logic        addr_fault_out,
    output logic        bus_err_out
);

    lsu_state_t  state_r, state_nxt_s;
    logic        access_s, fault_s, issue_s, stall_s, ready_hit_s, timeout_s;
    logic [15:0] wait_cnt_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        is_load_r;
    logic        req_r, we_r, load_valid_r, bus_err_r;
    logic [31:0] addr_r, wdata_r, load_data_r;
    logic [3:0]  be_r;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, align_data_s;

    assign access_s = mem_read_en_in | mem_write_en_in;

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata),
        .funct3 (f3_r),
        .offset (off_r),
        .data   (align_data_s)
    );

    // Lane enables by access width; store data replicated across lanes.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (mem_funct3_in[1:0])
            2'b00: begin
                be_s    = 4'b0001 << mem_alu_result_in[1:0];
                wdata_s = {4{mem_store_data_in[7:0]}};
            end
            2'b01: begin
                be_s    = mem_alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{mem_store_data_in[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = mem_store_data_in;
            end
        endcase
    end

    // Next state, issue decision, fault flag and stall request.
    always_comb begin
        state_nxt_s = state_r;
        fault_s     = 1'b0;
        issue_s     = 1'b0;
        stall_s     = 1'b0;
        ready_hit_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    fault_s = access_fault(mem_write_en_in, mem_funct3_in,
                                           mem_alu_result_in[1:0]);
                end else begin
                    fault_s = 1'b0;
                end
                if (access_s && !fault_s) begin
                    issue_s     = 1'b1;
                    stall_s     = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (dmem_ready) begin
                    ready_hit_s = 1'b1;
                    state_nxt_s = DONE;
                end else if ((MAX_WAIT > 0) && (wait_cnt_r == 16'(MAX_WAIT - 1))) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, request registers, wait counter and completion results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            be_r         <= 4'b0000;
            f3_r         <= 3'b000;
            off_r        <= 2'b00;
            is_load_r    <= 1'b0;
            wait_cnt_r   <= 16'h0000;
            load_valid_r <= 1'b0;
            bus_err_r    <= 1'b0;
            load_data_r  <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            req_r        <= (state_nxt_s == BUSY);
            load_valid_r <= ready_hit_s & is_load_r;
            bus_err_r    <= timeout_s;
            if (issue_s) begin
                we_r       <= mem_write_en_in;
                addr_r     <= {mem_alu_result_in[31:2], 2'b00};
                wdata_r    <= wdata_s;
                be_r       <= be_s;
                f3_r       <= mem_funct3_in;
                off_r      <= mem_alu_result_in[1:0];
                is_load_r  <= ~mem_write_en_in;
                wait_cnt_r <= 16'h0000;
            end else if (state_r == BUSY) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (ready_hit_s && is_load_r) begin
                load_data_r <= align_data_s;
            end else if (timeout_s && is_load_r) begin
                load_data_r <= 32'h0000_0000;
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

    assign dmem_req       = req_r;
    assign dmem_we        = we_r;
    assign dmem_addr      = addr_r;
    assign dmem_wdata     = wdata_r;
    assign dmem_be        = be_r;
    assign load_data_out  = load_data_r;
    assign load_valid_out = load_valid_r;
    assign bus_err_out    = bus_err_r;
    assign addr_fault_out = fault_s;
    assign stall_out      = stall_s & rst_n;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses checked against a behavioural model of the access rules.
module tb_mem_stage_lsu;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_alu_result_in, mem_store_data_in;
    logic [2:0]  mem_funct3_in;
    logic        mem_read_en_in, mem_write_en_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] load_data_out;
    logic        load_valid_out, stall_out, addr_fault_out, bus_err_out;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_load = 32'h0;

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_alu_result_in(mem_alu_result_in), .mem_store_data_in(mem_store_data_in),
        .mem_funct3_in(mem_funct3_in), .mem_read_en_in(mem_read_en_in),
        .mem_write_en_in(mem_write_en_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .stall_out(stall_out),
        .addr_fault_out(addr_fault_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full access: model the expected results, drive the EX/MEM inputs,
    // act as memory (ready after wait_n cycles, never if wait_n >= MAX_WAIT)
    // and check every cycle of the access.
    task automatic do_access(input logic we, input logic re, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rd, input int wait_n, input string tag);
        logic        is_store, legal, fault, to;
        int          size, n_busy;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, lane;
        is_store = we;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        if (is_store) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else          legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                              (f3 == 3'd4) || (f3 == 3'd5);
        fault = !legal || ((addr % 32'(size)) != 32'd0);
        ebe = 4'b0000;
        for (int i = 0; i < size; i++) ebe[int'(addr % 32'd4) + i] = 1'b1;
        if (size == 1)      ewd = 32'(sd[7:0]) * 32'h0101_0101;
        else if (size == 2) ewd = 32'(sd[15:0]) * 32'h0001_0001;
        else                ewd = sd;
        lane = rd >> (8 * (addr % 32'd4));
        if (size == 1) begin
            eld = lane & 32'hFF;
            if (f3 == 3'b000 && eld >= 32'd128) eld = eld + 32'hFFFF_FF00;
        end else if (size == 2) begin
            eld = lane & 32'hFFFF;
            if (f3 == 3'b001 && eld >= 32'd32768) eld = eld + 32'hFFFF_0000;
        end else begin
            eld = rd;
        end
        to     = (wait_n >= MAX_WAIT);
        n_busy = to ? MAX_WAIT : wait_n + 1;

        @(negedge clk);
        mem_alu_result_in = addr; mem_store_data_in = sd; mem_funct3_in = f3;
        mem_write_en_in = we; mem_read_en_in = re; dmem_ready = 1'b0;
        #1;
        checks++; if (addr_fault_out !== fault)
            begin errors++; $display("FAIL %s fault: got %0b want %0b", tag, addr_fault_out, fault); end
        checks++; if (stall_out !== !fault)
            begin errors++; $display("FAIL %s idle_stall: got %0b want %0b", tag, stall_out, !fault); end
        checks++; if (dmem_req !== 1'b0)
            begin errors++; $display("FAIL %s idle_req: got %0b want 0", tag, dmem_req); end
        if (fault) begin
            @(negedge clk); #1;
            checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0)
                begin errors++; $display("FAIL %s fault_noreq: req %0b stall %0b want 0 0", tag, dmem_req, stall_out); end
            mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
            return;
        end
        for (int k = 0; k < n_busy; k++) begin
            @(negedge clk);
            dmem_ready = (!to && k == wait_n);
            dmem_rdata = dmem_ready ? rd : $urandom;
            #1;
            checks++; if (dmem_req !== 1'b1 || stall_out !== 1'b1)
                begin errors++; $display("FAIL %s busy%0d: req %0b stall %0b want 1 1", tag, k, dmem_req, stall_out); end
            checks++; if (dmem_we !== is_store || dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== ebe)
                begin errors++; $display("FAIL %s busy%0d_bus: we %0b addr %h be %b want %0b %h %b",
                                         tag, k, dmem_we, dmem_addr, dmem_be, is_store, {addr[31:2], 2'b00}, ebe); end
            if (is_store) begin
                checks++; if (dmem_wdata !== ewd)
                    begin errors++; $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, ewd); end
            end
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        if (!is_store) exp_load = to ? 32'h0 : eld;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0)
            begin errors++; $display("FAIL %s done: req %0b stall %0b want 0 0", tag, dmem_req, stall_out); end
        checks++; if (load_valid_out !== (!is_store && !to) || bus_err_out !== to)
            begin errors++; $display("FAIL %s done_flags: valid %0b err %0b want %0b %0b",
                                     tag, load_valid_out, bus_err_out, (!is_store && !to), to); end
        checks++; if (load_data_out !== exp_load)
            begin errors++; $display("FAIL %s load_data: got %h want %h", tag, load_data_out, exp_load); end
        mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
        @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b0 || load_valid_out !== 1'b0 || bus_err_out !== 1'b0 || load_data_out !== exp_load)
            begin errors++; $display("FAIL %s after: req %0b valid %0b err %0b data %h want 0 0 0 %h",
                                     tag, dmem_req, load_valid_out, bus_err_out, load_data_out, exp_load); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        mem_alu_result_in = 32'h100; mem_store_data_in = 32'h0; mem_funct3_in = 3'b010;
        mem_read_en_in = 1'b1; mem_write_en_in = 1'b0;
        #12;
        checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_data_out,
                       load_valid_out, stall_out, bus_err_out} !== 104'h0)
            begin errors++; $display("FAIL reset_outputs: req %0b stall %0b be %b data %h want all 0",
                                     dmem_req, stall_out, dmem_be, load_data_out); end
        mem_read_en_in = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 2, "sw");
    endtask

    task automatic test_load_byte();
        do_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80FF_7F01, 0, "lb");
        checks++; if (load_data_out !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL lb_value: got %h want ffffff80", load_data_out); end
        do_access(1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 32'h80FF_7F01, 0, "lbu");
        checks++; if (load_data_out !== 32'h0000_0080)
            begin errors++; $display("FAIL lbu_value: got %h want 00000080", load_data_out); end
    endtask

    task automatic test_store_half();
        do_access(1'b1, 1'b0, 3'b001, 32'h302, 32'h0000_A5C3, 32'h0, 1, "sh");
        do_access(1'b0, 1'b1, 3'b101, 32'h302, 32'h0, 32'hA5C3_0000, 0, "lhu");
        checks++; if (load_data_out !== 32'h0000_A5C3)
            begin errors++; $display("FAIL lhu_value: got %h want 0000a5c3", load_data_out); end
    endtask

    task automatic test_fault();
        do_access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_misaligned");
        do_access(1'b1, 1'b0, 3'b100, 32'h104, 32'h0, 32'h0, 0, "store_bad_f3");
        do_access(1'b0, 1'b1, 3'b011, 32'h108, 32'h0, 32'h0, 0, "load_bad_f3");
    endtask

    task automatic test_timeout();
        do_access(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 32'h1234_5678, 0, "lw_pre");
        do_access(1'b0, 1'b1, 3'b010, 32'h404, 32'h0, 32'h0, MAX_WAIT, "lw_timeout");
        checks++; if (load_data_out !== 32'h0)
            begin errors++; $display("FAIL timeout_data: got %h want 0", load_data_out); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_alu_result_in = 32'h40; mem_funct3_in = 3'b010;
        mem_read_en_in = 1'b1; mem_write_en_in = 1'b0; dmem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b1)
            begin errors++; $display("FAIL mid_busy_req: got %0b want 1", dmem_req); end
        #2 rst_n = 1'b0;
        #1;
        exp_load = 32'h0;
        checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_data_out,
                       load_valid_out, stall_out, bus_err_out} !== 104'h0)
            begin errors++; $display("FAIL mid_reset_outputs: req %0b stall %0b addr %h data %h want all 0",
                                     dmem_req, stall_out, dmem_addr, load_data_out); end
        mem_read_en_in = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        do_access(1'b0, 1'b1, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1, "lw_after_reset");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we, re;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            do_access(we, re, f3, addr, $urandom, $urandom, $urandom_range(0, MAX_WAIT), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
